// File: rtl/wide_add_seq_if.sv
// rtl/wide_add_seq_if.sv - request/response bundle for the sequential 64-bit adder.
interface wide_add_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        output sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout
    );
endinterface

// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - 64-bit add/subtract computed as four 16-bit slices, one per cycle.
// Optional signed-overflow output ovf is enabled by defining WIDE_ADD_SEQ_OVF_EN.
module wide_add_seq (
    input  logic          clk,
    input  logic          rst,
    wide_add_seq_if.slave bus,
    output logic          busy
`ifdef WIDE_ADD_SEQ_OVF_EN
    ,
    output logic          ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic        carry_q, carry_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [63:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
`ifdef WIDE_ADD_SEQ_OVF_EN
    logic        ovf_q, ovf_d;
`endif

    logic [5:0]  slice_lsb;
    logic [16:0] slice_res;

    // b_q already holds the inverted operand for subtraction, so CALC is a pure add.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
`ifdef WIDE_ADD_SEQ_OVF_EN
        ovf_d       = ovf_q;
`endif
        slice_lsb   = {cnt_q, 4'h0};
        slice_res   = {1'b0, a_q[slice_lsb +: 16]} + {1'b0, b_q[slice_lsb +: 16]}
                    + {16'h0000, carry_q};

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub | bus.cin;
                    cnt_d   = 2'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d[slice_lsb +: 16] = slice_res[15:0];
                carry_d                = slice_res[16];
                if (cnt_q == 2'd3) begin
                    cout_d  = slice_res[16];
`ifdef WIDE_ADD_SEQ_OVF_EN
                    // carry into bit 63 recovered from its sum bit and operand bits
                    ovf_d   = slice_res[16] ^ (slice_res[15] ^ a_q[63] ^ b_q[63]);
`endif
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= 64'h0;
            b_q         <= 64'h0;
            carry_q     <= 1'b0;
            cnt_q       <= 2'd0;
            sum_q       <= 64'h0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef WIDE_ADD_SEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
`ifdef WIDE_ADD_SEQ_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign busy          = busy_q;
`ifdef WIDE_ADD_SEQ_OVF_EN
    assign ovf           = ovf_q;
`endif

endmodule

// File: tb/tb_wide_add_seq.sv
// tb/tb_wide_add_seq.sv - self-checking bench for wide_add_seq with a plain-arithmetic reference.
module tb_wide_add_seq;

    logic clk;
    logic rst;
    logic busy;
`ifdef WIDE_ADD_SEQ_OVF_EN
    logic ovf;
`endif

    int checks;
    int errors;

    wide_add_seq_if bus ();

    wide_add_seq dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
`ifdef WIDE_ADD_SEQ_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_junk();
        bus.in_valid = 1'b1;
        bus.a        = {$urandom, $urandom};
        bus.b        = {$urandom, $urandom};
        bus.cin      = 1'($urandom);
        bus.sub      = 1'($urandom);
    endtask

    // Full transaction: accept, check latency, result, hold in DONE, release.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sub, input int hold);
        logic [63:0] bb;
        logic [64:0] exp;
        logic        exp_ovf;
        int          waited;
        bb      = sub ? ~b : b;
        exp     = {1'b0, a} + {1'b0, bb} + 65'(sub ? 1'b1 : cin);
        exp_ovf = (a[63] == bb[63]) && (exp[63] != a[63]);

        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        chk("in_ready_before_accept", 64'(bus.in_ready), 64'd1);

        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        tick();
        chk("accept_in_ready", 64'(bus.in_ready), 64'd0);
        chk("accept_busy", 64'(busy), 64'd1);
        chk("accept_out_valid", 64'(bus.out_valid), 64'd0);

        for (int i = 1; i <= 4; i++) begin
            drive_junk();
            tick();
            chk(i < 4 ? "calc_out_valid" : "done_out_valid", 64'(bus.out_valid), 64'(i == 4));
        end
        chk("sum", bus.sum, exp[63:0]);
        chk("cout", 64'(bus.cout), 64'(exp[64]));
`ifdef WIDE_ADD_SEQ_OVF_EN
        chk("ovf", 64'(ovf), 64'(exp_ovf));
`else
        if (exp_ovf) begin
            waited = 0;
        end
`endif

        bus.out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            drive_junk();
            tick();
            chk("hold_sum", bus.sum, exp[63:0]);
            chk("hold_cout", 64'(bus.cout), 64'(exp[64]));
            chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end

        drive_junk();
        bus.out_ready = 1'b1;
        tick();
        chk("release_out_valid", 64'(bus.out_valid), 64'd0);
        chk("release_in_ready", 64'(bus.in_ready), 64'd1);
        chk("release_busy", 64'(busy), 64'd0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = 64'h0;
        bus.b         = 64'h0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;

        tick();
        tick();
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_sum", bus.sum, 64'h0);
        chk("reset_cout", 64'(bus.cout), 64'd0);
`ifdef WIDE_ADD_SEQ_OVF_EN
        chk("reset_ovf", 64'(ovf), 64'd0);
`endif
        rst = 1'b0;

        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 1);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0);
        run_op(64'd5, 64'd7, 1'b0, 1'b1, 2);
        run_op(64'd7, 64'd5, 1'b1, 1'b1, 0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1);
        run_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 0);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 10);

        // abort mid-calculation while slice 2 is in progress
        bus.in_valid = 1'b1;
        bus.a        = 64'hFFFF_0000_FFFF_0000;
        bus.b        = 64'h0001_0001_0001_0001;
        bus.cin      = 1'b0;
        bus.sub      = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_sum", bus.sum, 64'h0);
        chk("abort_cout", 64'(bus.cout), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_result", 64'(bus.out_valid), 64'd0);
        end
        run_op(64'hFFFF_0000_FFFF_0000, 64'h0001_0001_0001_0001, 1'b0, 1'b0, 1);

        for (int n = 0; n < 24; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: ra = 64'hFFFF_FFFF_FFFF_FFFF;
                1: rb = ra;
                2: ra = {1'b0, ra[62:0]};
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 Parameters: none; operand width fixed at 64 bits, processed as four 16-bit slices.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request present on a, b, cin, sub.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 a  input  64  operand A.
REQ-007 b  input  64  operand B.
REQ-008 cin  input  1  carry-in into slice 0; ignored when sub=1.
REQ-009 sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1).
REQ-010 out_valid  output  1  result on sum/cout is valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 sum  output  64  result.
REQ-013 cout  output  1  carry out of bit 63.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, CALC, DONE.
REQ-016 IDLE: in_ready=1; on in_valid, latch a, b (b inverted if sub), and the carry (1 if sub, else cin); clear slice counter; go to CALC.
REQ-017 CALC: one 16-bit slice per cycle, LSB slice first; slice k = a[16k+15:16k] + b'[16k+15:16k] + carry register; write to sum[16k+15:16k]; carry register takes slice carry-out.
REQ-018 Slice counter is 2 bits, 0..3; after slice 3, cout = final carry, state to DONE; no wrap back to 0 while in CALC.
REQ-019 Latency: acceptance at edge E0; slices written at E1..E4; out_valid=1 from the cycle after E4.
REQ-020 DONE: out_valid=1; sum and cout held stable until out_ready=1; on out_ready, go to IDLE at that edge.
REQ-021 in_ready=0 in CALC and DONE; in_valid there is ignored, and latched operands do not change.
REQ-022 Back-to-back: the next request is accepted no earlier than the cycle after the DONE->IDLE edge, giving a throughput of 1 result per 6 cycles minimum.
REQ-023 out_valid=0 in IDLE and CALC; sum bits of slices not yet computed are unspecified until out_valid.
REQ-024 Arithmetic is modulo 2^64; cout equals bit 64 of the 65-bit true sum of A + B' + carry-in.

Reset
REQ-025 rst=1 at an edge forces IDLE, slice counter 0, carry register 0, sum=0, cout=0, out_valid=0, busy=0; in_ready=1 in the first cycle after reset.
REQ-026 Reset mid-CALC or in DONE aborts the operation; no out_valid is produced for it.
REQ-027 rst has priority over in_valid and out_ready in the same cycle.

Configuration
REQ-028 Macro WIDE_ADD_SEQ_OVF_EN defined: extra output port ovf (1 bit) = signed two's-complement overflow of the 64-bit operation (carry into bit 63 XOR carry out of bit 63). ovf is valid with out_valid, held in DONE, and reset to 0.
REQ-029 Macro WIDE_ADD_SEQ_OVF_EN undefined: the ovf port and its logic are absent; all other behaviour is identical.

Verification
REQ-030 a=0x0000_0000_0000_FFFF, b=1, cin=0, sub=0 -> sum=0x0000_0000_0001_0000, cout=0, out_valid 4 cycles after acceptance (slice carry propagates).
REQ-031 a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1; ovf=0 with the macro defined.
REQ-032 a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0; a=7, b=5, sub=1 -> sum=2, cout=1.
REQ-033 a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 (macro defined) -> sum=0x8000_0000_0000_0000, ovf=1, cout=0.
REQ-034 out_ready held 0 for 10 cycles in DONE, in_valid=1 with new operands -> sum stable, in_ready=0, new request accepted only after the DONE->IDLE transition.
REQ-035 rst pulsed at slice 2 of CALC -> next cycle IDLE, out_valid=0, sum=0; a fresh request then completes correctly.
